// File: rtl/secded_pkg.sv
// Shared SECDED helpers: parity-bit count, power-of-two test and error classification.
package secded_pkg;

  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_kind_e;

  // Smallest p with 2**p >= data_w + p + 1.
  function automatic int unsigned secded_p(input int unsigned data_w);
    int unsigned p;
    p = 0;
    while ((32'd1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic logic is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a SECDED code word.
module secded_syndrome #(
  parameter int unsigned CODE_W = 13,
  parameter int unsigned P      = 4
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [P-1:0]      syndrome_o,
  output logic              parity_o
);

  // Bit 0 is the overall parity and carries no position weight.
  always_comb begin
    syndrome_o = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (code_i[i]) syndrome_o = syndrome_o ^ P'(i);
    end
  end

  assign parity_o = ^code_i;

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready streaming and saturating error counters.
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned P      = secded_p(DATA_W),
  localparam int unsigned CODE_W = DATA_W + P + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_err1,
  output logic              out_err2,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_err1,
  output logic [CNT_W-1:0]  cnt_err2
);

  logic [P-1:0]      syn;
  logic              par;

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [P-1:0]      out_syndrome_q, out_syndrome_d;
  logic              out_err1_q, out_err1_d;
  logic              out_err2_q, out_err2_d;

  logic [CNT_W-1:0]  cnt_err1_q, cnt_err1_d;
  logic [CNT_W-1:0]  cnt_err2_q, cnt_err2_d;

  logic              s1_adv;
  logic              fire;
  err_kind_e         kind;
  logic [CODE_W-1:0] fixed;
  logic [DATA_W-1:0] data;

  secded_syndrome #(
    .CODE_W(CODE_W),
    .P     (P)
  ) u_syndrome (
    .code_i    (in_code),
    .syndrome_o(syn),
    .parity_o  (par)
  );

  // Classify and correct the stage-1 word; uncorrectable words pass through raw.
  always_comb begin : p_decode
    int unsigned j;
    kind  = ERR_NONE;
    fixed = s1_code_q;
    if (s1_par_q) begin
      if (32'(s1_syn_q) < CODE_W) begin
        kind = ERR_SINGLE;
        for (int unsigned i = 1; i < CODE_W; i++) begin
          if (P'(i) == s1_syn_q) fixed[i] = ~fixed[i];
        end
      end else begin
        kind = ERR_DOUBLE;
      end
    end else if (s1_syn_q != '0) begin
      kind = ERR_DOUBLE;
    end
    data = '0;
    j    = 0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (!is_pow2(i)) begin
        data[j] = fixed[i];
        j++;
      end
    end
  end

  always_comb begin
    s1_adv   = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s1_adv;
    fire     = out_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = syn;
        s1_par_d  = par;
      end
    end

    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_syndrome_d = out_syndrome_q;
    out_err1_d     = out_err1_q;
    out_err2_d     = out_err2_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d     = data;
        out_syndrome_d = s1_syn_q;
        out_err1_d     = (kind == ERR_SINGLE);
        out_err2_d     = (kind == ERR_DOUBLE);
      end
    end

    // Clear takes priority over a same-cycle increment.
    cnt_err1_d = cnt_err1_q;
    cnt_err2_d = cnt_err2_q;
    if (cnt_clear) begin
      cnt_err1_d = '0;
      cnt_err2_d = '0;
    end else if (fire) begin
      if (out_err1_q && (cnt_err1_q != '1)) cnt_err1_d = cnt_err1_q + CNT_W'(1);
      if (out_err2_q && (cnt_err2_q != '1)) cnt_err2_d = cnt_err2_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q     <= 1'b0;
      s1_code_q      <= '0;
      s1_syn_q       <= '0;
      s1_par_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_syndrome_q <= '0;
      out_err1_q     <= 1'b0;
      out_err2_q     <= 1'b0;
      cnt_err1_q     <= '0;
      cnt_err2_q     <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_code_q      <= s1_code_d;
      s1_syn_q       <= s1_syn_d;
      s1_par_q       <= s1_par_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_syndrome_q <= out_syndrome_d;
      out_err1_q     <= out_err1_d;
      out_err2_q     <= out_err2_d;
      cnt_err1_q     <= cnt_err1_d;
      cnt_err2_q     <= cnt_err2_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_syndrome = out_syndrome_q;
  assign out_err1     = out_err1_q;
  assign out_err2     = out_err2_q;
  assign cnt_err1     = cnt_err1_q;
  assign cnt_err2     = cnt_err2_q;

endmodule
